// File: rtl/bist_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | bist_seq_ctrl: ALU BIST sequencer (pattern reset, opcode, ROM address,   |
// | result compare). Optional MISR signature when BIST_MISR_EN is defined.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bist_seq_ctrl #(
  parameter int NUM_VECTORS = 256,
  parameter int ADDR_W      = 8,
  parameter int SEL_W       = 4,
  parameter int DATA_W      = 9,
  parameter int FCNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] rom_data,
  output logic              gen_rst,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FCNT_W-1:0] fail_cnt,
  output logic [ADDR_W-1:0] first_fail,
  output logic [DATA_W-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // One extra bit so a full 2**ADDR_W run does not alias back to zero.
  localparam logic [ADDR_W:0] LAST_VEC = (ADDR_W+1)'(NUM_VECTORS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     vec_cnt_q, vec_cnt_d;
  logic [FCNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [ADDR_W-1:0]   first_fail_q, first_fail_d;
  logic                gen_rst_q, gen_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                mismatch;
  logic                go;
`ifdef BIST_MISR_EN
  logic [DATA_W-1:0]   sig_q, sig_d;
`endif

  assign mismatch = (alu_data != rom_data);
  assign go       = start && !abort;

  always_comb begin
    state_d      = state_q;
    vec_cnt_d    = vec_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
`ifdef BIST_MISR_EN
    sig_d        = sig_q;
`endif
    case (state_q)
      S_IDLE: if (go) state_d = S_INIT;
      S_INIT: state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (mismatch) begin
            if (fail_cnt_q == '0) first_fail_d = vec_cnt_q[ADDR_W-1:0];
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + FCNT_W'(1);
          end
`ifdef BIST_MISR_EN
          sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1] ^ sig_q[4]} ^ alu_data;
`endif
          vec_cnt_d = vec_cnt_q + 1'b1;
          if (vec_cnt_q == LAST_VEC) state_d = S_DONE;
        end
      end
      S_DONE: if (go) state_d = S_INIT;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_INIT) begin
      vec_cnt_d    = '0;
      fail_cnt_d   = '0;
      first_fail_d = '0;
`ifdef BIST_MISR_EN
      sig_d        = '0;
`endif
    end

    gen_rst_d = (state_d != S_RUN);
    busy_d    = (state_d == S_INIT) || (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
    // The verdict is taken once, on the final compare, and then held.
    if (state_d == S_DONE) pass_d = (state_q == S_RUN) ? (fail_cnt_d == '0) : pass_q;
    else                   pass_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      vec_cnt_q    <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      gen_rst_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_cnt_q    <= vec_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      gen_rst_q    <= gen_rst_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

`ifdef BIST_MISR_EN
  always_ff @(posedge clk) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_d;
  end
  assign signature = sig_q;
`else
  assign signature = '0;
`endif

  assign gen_rst    = gen_rst_q;
  assign alu_sel    = vec_cnt_q[SEL_W-1:0];
  assign rom_addr   = vec_cnt_q[ADDR_W-1:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_cnt   = fail_cnt_q;
  assign first_fail = first_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_bist_seq_ctrl: scoreboard bench for bist_seq_ctrl with a ROM/ALU model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bist_seq_ctrl;

  localparam int NV = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] alu_data, rom_data;
  logic       gen_rst, busy, done, pass;
  logic [3:0] alu_sel;
  logic [7:0] rom_addr, fail_cnt, first_fail;
  logic [8:0] signature;

  logic [NV-1:0] err_mask = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       pass;
    logic [7:0] fcnt;
    logic [7:0] ff;
    logic [8:0] sig;
  } exp_t;

  exp_t sb_q[$];

  bist_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .alu_data(alu_data), .rom_data(rom_data),
    .gen_rst(gen_rst), .alu_sel(alu_sel), .rom_addr(rom_addr),
    .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
    .first_fail(first_fail), .signature(signature)
  );

  always #5 clk = ~clk;

  // ROM holds 9'h1A5 ^ index; the ALU model flips the MSB on injected vectors.
  always_comb begin
    rom_data = 9'h1A5 ^ {1'b0, rom_addr};
    alu_data = rom_data ^ (err_mask[rom_addr] ? 9'h100 : 9'h000);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t calc_exp();
    exp_t e;
    logic [8:0] s, a;
    int n;
    e.pass = 1'b1; e.fcnt = 8'd0; e.ff = 8'd0; s = 9'd0; n = 0;
    for (int i = 0; i < NV; i++) begin
      a = 9'h1A5 ^ 9'(i) ^ (err_mask[i] ? 9'h100 : 9'h000);
      if (err_mask[i]) begin
        if (n == 0) e.ff = 8'(i);
        n++;
        e.pass = 1'b0;
      end
      s = {s[7:0], s[8] ^ s[4]} ^ a;
    end
    e.fcnt = (n > 255) ? 8'd255 : 8'(n);
`ifdef BIST_MISR_EN
    e.sig = s;
`else
    e.sig = 9'd0;
`endif
    return e;
  endfunction

  // Monitor: address/opcode sequence during RUN, run length, and result pop on done.
  logic [8:0] exp_idx = '0;
  int         busy_cnt = 0;
  logic       done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (busy && !gen_rst) begin
        check("run_addr", {24'd0, rom_addr}, {24'd0, exp_idx[7:0]});
        check("run_sel", {28'd0, alu_sel}, {28'd0, exp_idx[3:0]});
        exp_idx = exp_idx + 9'd1;
      end else begin
        exp_idx = '0;
      end
      if (done && !done_prev) begin
        check("busy_cycles", busy_cnt, NV + 1);
        check("done_busy", {31'd0, busy}, 0);
        check("done_genrst", {31'd0, gen_rst}, 1);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sb_q.pop_front();
          check("pass", {31'd0, pass}, {31'd0, e.pass});
          check("fail_cnt", {24'd0, fail_cnt}, {24'd0, e.fcnt});
          check("first_fail", {24'd0, first_fail}, {24'd0, e.ff});
          check("signature", {23'd0, signature}, {23'd0, e.sig});
        end
      end
      if (busy) busy_cnt++;
      else      busy_cnt = 0;
    end
    done_prev = done;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_genrst"}, {31'd0, gen_rst}, 1);
    check({tag, "_sel"}, {28'd0, alu_sel}, 0);
    check({tag, "_addr"}, {24'd0, rom_addr}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_pass"}, {31'd0, pass}, 0);
    check({tag, "_fcnt"}, {24'd0, fail_cnt}, 0);
    check({tag, "_ff"}, {24'd0, first_fail}, 0);
    check({tag, "_sig"}, {23'd0, signature}, 0);
  endtask

  task automatic start_run(input bit push);
    if (push) sb_q.push_back(calc_exp());
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check("init_busy", {31'd0, busy}, 1);
    check("init_done", {31'd0, done}, 0);
    check("init_fcnt", {24'd0, fail_cnt}, 0);
    check("init_ff", {24'd0, first_fail}, 0);
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
    repeat (2) @(negedge clk);
  endtask

  // Returns at the negedge where the DUT is in RUN presenting vector addr.
  task automatic wait_addr(input logic [7:0] addr);
    int n = 0;
    @(negedge clk);
    while (!(busy && !gen_rst && rom_addr == addr) && n < 2000) begin
      @(negedge clk); n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL addr_timeout actual=%0h required=%0h", rom_addr, addr);
    end
  endtask

  initial begin
    // Reset values
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);

    // All vectors match
    err_mask = '0;
    start_run(1'b1);
    wait_done();
    // abort in DONE has no effect
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_in_done", {31'd0, done}, 1);
    @(negedge clk) abort = 1'b0;

    // Two mismatches
    err_mask = '0; err_mask[5] = 1'b1; err_mask[200] = 1'b1;
    start_run(1'b1);
    wait_done();

    // Mismatch everywhere, counter saturates
    err_mask = '1;
    start_run(1'b1);
    wait_done();

    // Abort at vector 100 after a mismatch at 50
    err_mask = '0; err_mask[50] = 1'b1;
    start_run(1'b0);
    wait_addr(8'd100);
    abort = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_pass", {31'd0, pass}, 0);
    check("abort_genrst", {31'd0, gen_rst}, 1);
    check("abort_fcnt", {24'd0, fail_cnt}, 1);
    check("abort_ff", {24'd0, first_fail}, 50);
    @(negedge clk) abort = 1'b0;
    repeat (2) @(negedge clk);
    err_mask = '0;
    start_run(1'b1);
    wait_done();

    // start during RUN ignored; start from DONE re-runs with cleared results
    err_mask = '0; err_mask[3] = 1'b1;
    start_run(1'b1);
    wait_addr(8'd20);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done();
    err_mask = '0; err_mask[9] = 1'b1;
    start_run(1'b1);
    wait_done();

    // Reset at vector 30
    err_mask = '0; err_mask[10] = 1'b1;
    start_run(1'b0);
    wait_addr(8'd30);
    reset = 1'b1;
    @(posedge clk); #1 check_reset_vals("midrun_reset");
    @(negedge clk) reset = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_reset", {31'd0, done}, 0);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
